membus_master: RTL

//  Processor-side sequencer for one PDP-6 memory bus port. Turns a single client

---
 rtl/membus_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/membus_master.sv
// membus_master: turns one client read/write/read-modify-write request into the
// PDP-6 memory bus handshake, with a timeout that flags nonexistent memory.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start with a non-zero op
// ADDR   | request levels, ma and sel on the bus; waiting for addr_ack
// RDWAIT | request levels down; ORing mb_in until rd_rs is seen high
// RDTAIL | RD_SETTLE cycles of ORing, then one rdata_vld cycle
// MODIFY | rmw only: holding until the client strobes modified data
// WDATA  | one quiet cycle, then WR_PULSE cycles of write data on mb_out
// WRS    | wr_rs high for WRS_LEN cycles, mb_out back at zero
// DONE   | done pulse, back to IDLE
module membus_master #(
  parameter int ACK_TIMEOUT = 1000,
  parameter int RD_SETTLE   = 4,
  parameter int WR_PULSE    = 4,
  parameter int WRS_LEN     = 2,
  parameter bit FMC_EN      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [17:0] addr,
  input  logic [35:0] wdata,
  input  logic        wdata_stb,
  output logic        busy,
  output logic [35:0] rdata,
  output logic        rdata_vld,
  output logic        done,
  output logic        nxm,
  output logic        membus_rq_cyc,
  output logic        membus_rd_rq,
  output logic        membus_wr_rq,
  output logic [14:0] membus_ma,
  output logic [3:0]  membus_sel,
  output logic        membus_fmc_select,
  output logic [35:0] membus_mb_out,
  output logic        membus_wr_rs,
  input  logic        membus_addr_ack,
  input  logic        membus_rd_rs,
  input  logic [35:0] membus_mb_in
);

  // PDP-6 bit 35 is the LSB, so addr[18:21] maps to addr[17:14] and addr[21:35] to addr[14:0].
  localparam int CNT_W = $clog2(ACK_TIMEOUT + RD_SETTLE + WR_PULSE + WRS_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RDWAIT, S_RDTAIL, S_MODIFY, S_WDATA, S_WRS, S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_load;
  logic               cnt_zero;
  logic [1:0]         op_q;
  logic [17:0]        addr_q;
  logic [35:0]        wdata_q;
  logic               accept;
  logic               timeout;
  logic               or_en;

  assign cnt_zero = (cnt == '0);
  assign accept   = (state == S_IDLE) && start && (op != 2'b00);
  assign timeout  = cnt_zero && (((state == S_ADDR) && !membus_addr_ack) ||
                                 ((state == S_RDWAIT) && !membus_rd_rs));
  assign or_en    = (state == S_ADDR) || (state == S_RDWAIT) ||
                    ((state == S_RDTAIL) && !cnt_zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ADDR;
      S_ADDR: begin
        // addr_ack takes priority over a timeout landing in the same cycle
        if (membus_addr_ack) state_nxt = op_q[0] ? S_RDWAIT : S_WDATA;
        else if (cnt_zero)   state_nxt = S_DONE;
      end
      S_RDWAIT: begin
        if (membus_rd_rs)    state_nxt = S_RDTAIL;
        else if (cnt_zero)   state_nxt = S_DONE;
      end
      S_RDTAIL: if (cnt_zero) state_nxt = op_q[1] ? S_MODIFY : S_DONE;
      S_MODIFY: if (wdata_stb) state_nxt = S_WDATA;
      S_WDATA:  if (cnt_zero) state_nxt = S_WRS;
      S_WRS:    if (cnt_zero) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // WDATA loads WR_PULSE (not WR_PULSE-1) to get the leading zero cycle on mb_out
  always_comb begin
    cnt_load = '0;
    case (state_nxt)
      S_ADDR, S_RDWAIT: cnt_load = CNT_W'(ACK_TIMEOUT - 1);
      S_RDTAIL:         cnt_load = CNT_W'(RD_SETTLE);
      S_WDATA:          cnt_load = CNT_W'(WR_PULSE);
      S_WRS:            cnt_load = CNT_W'(WRS_LEN - 1);
      default:          cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      nxm     <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        cnt <= cnt_load;
      end else if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (accept) begin
        op_q   <= op;
        addr_q <= addr;
        rdata  <= '0;
        nxm    <= 1'b0;
        if (op == 2'b10) wdata_q <= wdata;
      end else if (or_en) begin
        rdata <= rdata | membus_mb_in;
      end

      if ((state == S_MODIFY) && wdata_stb) wdata_q <= wdata;
      if (timeout) nxm <= 1'b1;
    end
  end

  always_comb begin
    busy              = (state != S_IDLE);
    done              = (state == S_DONE);
    rdata_vld         = (state == S_RDTAIL) && cnt_zero;
    membus_rq_cyc     = 1'b0;
    membus_rd_rq      = 1'b0;
    membus_wr_rq      = 1'b0;
    membus_ma         = '0;
    membus_sel        = '0;
    membus_fmc_select = 1'b0;
    membus_mb_out     = '0;
    membus_wr_rs      = 1'b0;
    case (state)
      S_ADDR: begin
        membus_rq_cyc     = 1'b1;
        membus_rd_rq      = op_q[0];
        membus_wr_rq      = op_q[1];
        membus_ma         = addr_q[14:0];
        membus_sel        = addr_q[17:14];
        membus_fmc_select = FMC_EN && (addr_q[17:4] == 14'd0);
      end
      S_WDATA: if (cnt != CNT_W'(WR_PULSE)) membus_mb_out = wdata_q;
      S_WRS:   membus_wr_rs = 1'b1;
      default: ;
    endcase
  end

endmodule
